// File: rtl/data_cache_wt.sv
`default_nettype none
// ============================================================================
// Module  : data_cache_wt
// Brief   : Direct-mapped, write-through, no-write-allocate data cache with
//           multi-word line refill over a req/ack port and hit/miss counters.
// Revision: 1.0
// ============================================================================
module data_cache_wt #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 256,
    parameter int WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] aluResult,
    input  logic [DATA_W-1:0] writeDataMem,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              flush,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck,
    output logic [31:0]       hitCount,
    output logic [31:0]       missCount
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_REFILL = 2'd1;
    localparam logic [1:0] C_WRITE  = 2'd2;
    localparam logic [1:0] C_DONE   = 2'd3;

    localparam logic [OFF_W-1:0] C_LAST_BEAT = OFF_W'(WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic [OFF_W-1:0]  r_beat;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES*WORDS];
    logic [31:0]       r_hitCount;
    logic [31:0]       r_missCount;

    logic [OFF_W-1:0]  w_offset;
    logic [IDX_W-1:0]  w_index;
    logic [TAG_W-1:0]  w_tag;
    logic              w_isWrite;
    logic              w_isRead;
    logic              w_access;
    logic              w_hit;
    logic              w_beatAck;
    logic              w_ackLast;
    logic              w_stall;
    logic [DATA_W-1:0] w_storedWord;

    assign w_offset     = aluResult[OFF_W-1:0];
    assign w_index      = aluResult[OFF_W +: IDX_W];
    assign w_tag        = aluResult[ADDR_W-1 -: TAG_W];
    // A store takes priority; a simultaneous load is dropped entirely.
    assign w_isWrite    = MemWrite;
    assign w_isRead     = MemRead & ~MemWrite;
    assign w_access     = MemRead | MemWrite;
    assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_beatAck    = (r_state == C_REFILL) && memAck;
    assign w_ackLast    = w_beatAck && (r_beat == C_LAST_BEAT);
    assign w_storedWord = r_data[{w_index, w_offset}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_isWrite) begin
                    w_nextState = C_WRITE;
                end else if (w_isRead && !w_hit) begin
                    w_nextState = C_REFILL;
                end
            end
            C_REFILL: begin
                if (w_ackLast) begin
                    w_nextState = C_DONE;
                end
            end
            C_WRITE: begin
                if (memAck) begin
                    w_nextState = C_DONE;
                end
            end
            default: w_nextState = C_IDLE;
        endcase
    end

    always_comb begin
        w_stall  = 1'b0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWData = '0;
        case (r_state)
            C_IDLE: begin
                w_stall = w_isWrite | (w_isRead & ~w_hit);
            end
            C_REFILL: begin
                w_stall = 1'b1;
                memReq  = 1'b1;
                memAddr = {w_tag, w_index, r_beat};
            end
            C_WRITE: begin
                w_stall  = 1'b1;
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = aluResult;
                memWData = writeDataMem;
            end
            default: w_stall = 1'b0;
        endcase
        stall    = w_stall;
        readData = (w_isRead && !w_stall) ? w_storedWord : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (r_state == C_IDLE) begin
            r_beat <= '0;
        end else if (w_beatAck) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    // Valid is set only on the final beat, so an interrupted refill leaves the line invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if ((r_state == C_IDLE) && flush && !w_access) begin
            r_valid <= '0;
        end else if (w_ackLast) begin
            r_valid[w_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_beatAck) begin
            r_data[{w_index, r_beat}] <= memRData;
        end
        if (w_ackLast) begin
            r_tag[w_index] <= w_tag;
        end
        if ((r_state == C_WRITE) && memAck && w_hit) begin
            r_data[{w_index, w_offset}] <= writeDataMem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else if ((r_state == C_IDLE) && w_access) begin
            if (w_hit) begin
                if (r_hitCount != '1) begin
                    r_hitCount <= r_hitCount + 32'd1;
                end
            end else if (r_missCount != '1) begin
                r_missCount <= r_missCount + 32'd1;
            end
        end
    end

    assign hitCount  = r_hitCount;
    assign missCount = r_missCount;

endmodule
`default_nettype wire

// File: tb/tb_data_cache_wt.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_cache_wt
// Brief   : Directed scoreboard bench for data_cache_wt against a flat memory model.
// Revision: 1.0
// ============================================================================
module tb_data_cache_wt;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LINES  = 256;
    localparam int WORDS  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] aluResult;
    logic [DATA_W-1:0] writeDataMem;
    logic              MemRead;
    logic              MemWrite;
    logic              flush;
    logic [DATA_W-1:0] readData;
    logic              stall;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData;
    logic              memAck;
    logic [31:0]       hitCount;
    logic [31:0]       missCount;

    logic              ackEn;
    logic [31:0]       memModel [logic [31:0]];
    logic [31:0]       sb [$];
    int                nAsserts = 0;
    int                nFails   = 0;
    int                expHitCnt = 0;
    int                expMissCnt = 0;

    data_cache_wt #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS(WORDS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .aluResult(aluResult), .writeDataMem(writeDataMem),
        .MemRead(MemRead), .MemWrite(MemWrite), .flush(flush), .readData(readData),
        .stall(stall), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWData(memWData), .memRData(memRData), .memAck(memAck),
        .hitCount(hitCount), .missCount(missCount)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (memModel.exists(a)) return memModel[a];
        return a + 32'h100;
    endfunction

    always_comb memRData = modelRead(memAddr);
    assign memAck = memReq & ackEn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one access (called at posedge+2) and follows it to completion.
    task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic expHit,
                             input int holdAt, input int holdLen);
        int expStall, stallCyc, n, beats;
        logic done;
        logic [31:0] expAddr;
        if (wr) expStall = 2 + holdLen;
        else    expStall = expHit ? 0 : WORDS + 1 + holdLen;
        if (rd && !wr) sb.push_back(modelRead(addr));
        if (wr) memModel[addr] = wdata;
        if (expHit) expHitCnt++; else expMissCnt++;
        MemRead = rd; MemWrite = wr; aluResult = addr; writeDataMem = wdata;
        stallCyc = 0; n = 0; beats = 0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (stall) begin
                stallCyc++;
                if (memReq) begin
                    expAddr = wr ? addr : {addr[31:2], 2'(beats)};
                    check("memWe", {31'd0, memWe}, {31'd0, wr});
                    check("memAddr", memAddr, expAddr);
                    if (wr) check("memWData", memWData, wdata);
                    ackEn = !(n >= holdAt && n < holdAt + holdLen);
                    if (ackEn) beats++;
                    n++;
                end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
                check("stallCycles", stallCyc, expStall);
                check("memReqDone", {31'd0, memReq}, 32'd0);
                if (rd && !wr) check("readData", readData, sb.pop_front());
                else           check("readDataZero", readData, 32'd0);
            end
        end
        if (!done) check("timeout", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; ackEn = 1'b0;
        #1;
        check("hitCount", hitCount, expHitCnt);
        check("missCount", missCount, expMissCnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; aluResult = '0; writeDataMem = '0;
        MemRead = 1'b0; MemWrite = 1'b0; flush = 1'b0; ackEn = 1'b0;
        #12;
        check("rstStall", {31'd0, stall}, 32'd0);
        check("rstMemReq", {31'd0, memReq}, 32'd0);
        check("rstMemWe", {31'd0, memWe}, 32'd0);
        check("rstMemAddr", memAddr, 32'd0);
        check("rstMemWData", memWData, 32'd0);
        check("rstHit", hitCount, 32'd0);
        check("rstMiss", missCount, 32'd0);
        MemRead = 1'b1; aluResult = 32'h10;
        #1;
        check("rstStallReq", {31'd0, stall}, 32'd1);
        check("rstReadData", readData, 32'd0);
        MemRead = 1'b0;
        #9 rst_n = 1'b1;
        @(posedge clk); #2;

        runAccess(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0, 0);
        runAccess(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 0, 0);
        runAccess(1'b0, 1'b1, 32'h11, 32'hDEADBEEF, 1'b1, 0, 2);
        runAccess(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 0, 0);
        runAccess(1'b0, 1'b1, 32'h2000, 32'h12345678, 1'b0, 0, 0);
        runAccess(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 0, 0);
        runAccess(1'b1, 1'b0, 32'h10 + LINES*WORDS, 32'h0, 1'b0, 0, 0);
        runAccess(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 2, 5);
        runAccess(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 0, 0);
        runAccess(1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 0, 0);

        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flushHit", hitCount, expHitCnt);
        check("flushMiss", missCount, expMissCnt);
        runAccess(1'b1, 1'b0, 32'h12, 32'h0, 1'b0, 0, 0);

        runAccess(1'b1, 1'b1, 32'h13, 32'hCAFEF00D, 1'b1, 0, 0);
        runAccess(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 0, 0);

        MemRead = 1'b1; aluResult = 32'h40; ackEn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (memReq && memAddr == 32'h42) break;
        end
        check("beat2Addr", memAddr, 32'h42);
        rst_n = 1'b0;
        #1;
        check("asyncMemReq", {31'd0, memReq}, 32'd0);
        check("asyncStall", {31'd0, stall}, 32'd1);
        check("asyncHit", hitCount, 32'd0);
        check("asyncMiss", missCount, 32'd0);
        expHitCnt = 0; expMissCnt = 0;
        MemRead = 1'b0; ackEn = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        runAccess(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 0, 0);
        runAccess(1'b1, 1'b0, 32'h43, 32'h0, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
`default_nettype wire
